mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Arbitrates the instruction and data cache ports of `CPUS` pipelined cores onto the single shared RAM port. A two-state grant machine selects one requester at a time: data requests beat instruction requests, and cores are served round-robin. The arbiter then drives the RAM from that requester and returns the RAM's completion as that requester's `wait` deassertion. It sits between the per-core cache ports that feed the datapath and the RAM model.

## Interface

Parameters:
- `CPUS`, default 2: number of cores. Each core has one I-port and one D-port. Legal values are 1 to 4.

Ports:
- `CLK`: in, 1. System clock, rising edge.
- `nRST`: in, 1. Reset, asynchronous, active-low.
- `iREN`: in, CPUS. Instruction read request, one bit per core.
- `iaddr`: in, 32*CPUS. Instruction address. Core n uses bits [32n+31:32n].
- `iwait`: out, CPUS. High while an I-request is not complete.
- `iload`: out, 32*CPUS. Instruction read data.
- `dREN`: in, CPUS. Data read request.
- `dWEN`: in, CPUS. Data write request. `dREN` and `dWEN` are never both high for the same core.
- `daddr`: in, 32*CPUS. Data address.
- `dstore`: in, 32*CPUS. Data write value.
- `dwait`: out, CPUS. High while a D-request is not complete.
- `dload`: out, 32*CPUS. Data read data.
- `ramREN`: out, 1. RAM read strobe.
- `ramWEN`: out, 1. RAM write strobe.
- `ramaddr`: out, 32. RAM address.
- `ramstore`: out, 32. RAM write data.
- `ramload`: in, 32. RAM read data.
- `ramstate`: in, 2. RAM status: FREE=0, BUSY=1, ACCESS=2, ERROR=3.
- `err_count`: out, 8. Number of cycles spent in ERROR while granted. Saturates at 255.

## Operation

- States are IDLE and GRANT. Registered state:
  - `state`
  - `gcore`, log2(CPUS) bits, minimum 1
  - `gdata`, 1 bit: 1 = D-port, 0 = I-port
  - `rr`, round-robin pointer
  - `err_count`
- Request vector, per core n: `dreq[n] = dREN[n] | dWEN[n]`, `ireq[n] = iREN[n]`.
- Selection in IDLE:
  - If any `dreq` is set, choose the first core with `dreq` set, scanning `rr`, `rr+1`, … mod CPUS. Set `gdata = 1`.
  - Otherwise, if any `ireq` is set, choose the first core with `ireq` set in the same scan order. Set `gdata = 0`.
  - Otherwise, stay in IDLE.
- IDLE → GRANT: on the edge after a selection, latch `gcore` and `gdata`.
- Outputs in IDLE: `ramREN = ramWEN = 0`, `ramaddr = 0`, `ramstore = 0`.
- RAM drive in GRANT, from the granted port's live inputs:
  - D-port: `ramREN = dREN[gcore]`, `ramWEN = dWEN[gcore]`, `ramaddr = daddr[gcore]`, `ramstore = dstore[gcore]`.
  - I-port: `ramREN = iREN[gcore]`, `ramWEN = 0`, `ramaddr = iaddr[gcore]`, `ramstore = 0`.
- Completion: in GRANT with `ramstate == ACCESS`, the granted `wait` bit is 0 for that cycle only. On the next edge: state → IDLE, `rr` ← (`gcore` + 1) mod CPUS.
- Waits: every other `iwait` and `dwait` bit is 1 in every cycle, whether or not that port is requesting.
- Load data: `iload[n]` and `dload[n]` equal `ramload` for all n at all times. Only the port whose wait is low samples it.
- Abort: if the granted port's request drops in GRANT, go to IDLE on the next edge with no ack and no `rr` update. The RAM strobes follow the live request, so they are already low in that cycle.
- FREE and BUSY in GRANT: hold the grant.
- ERROR in GRANT: hold the grant, keep the wait high, and increment `err_count` unless it is 255.

## Timing

- Reset values:
  - `state` = IDLE, `rr` = 0, `gcore` = 0, `gdata` = 0, `err_count` = 0.
  - All `iwait`/`dwait` = 1.
  - RAM outputs = 0.
- Reset mid-GRANT: the RAM strobes drop to 0 asynchronously, without waiting for a clock edge.
- Latency: a request first seen in IDLE in cycle t is driven to the RAM in cycle t+1.
  - The earliest ack is cycle t+1, if `ramstate == ACCESS` then.
  - With k BUSY cycles, the ack is in cycle t+1+k.
- Back-to-back: at least one IDLE cycle separates grants, so the minimum occupancy per transaction is 2 cycles.
- A request must stay asserted, with a stable address and data, until its wait is low.
- Combinational paths:
  - `gcore`/`gdata` → RAM outputs.
  - `ramstate` → waits.
  - There is no combinational path from requester inputs to waits.
- With CPUS = 1, `rr` stays 0 and selection is just D over I.

## Test plan

1. **Single I-read with BUSY cycles.** Core 0 `iREN` at `iaddr = 0x40`; `ramstate` BUSY for 2 cycles, then ACCESS with `ramload = 0xDEADBEEF`. Required: `ramREN = 1` and `ramaddr = 0x40` from t+1; `iwait[0] = 0` and `iload[0] = 0xDEADBEEF` only at t+3; IDLE at t+4.
2. **D over I, same core.** Core 0 raises `iREN` and `dREN` in the same cycle, RAM at ACCESS immediately. Required: the D-port is acked at t+1; the I-port is acked at t+3 (IDLE at t+2, re-grant at the t+2 edge).
3. **Round-robin fairness.** Both cores hold `dREN` continuously, RAM at ACCESS immediately. Required: grant order is core 0, 1, 0, 1, and `rr` alternates.
4. **Data write.** Core 1 `dWEN`, `daddr = 0x100`, `dstore = 0x12345678`. Required: `ramWEN = 1`, `ramaddr = 0x100`, `ramstore = 0x12345678`, `ramREN = 0`; `dwait[1] = 0` on the ACCESS cycle.
5. **Abort.** The granted `dREN` drops while the RAM is BUSY. Required: RAM strobes 0 in that cycle, state IDLE on the next edge, no wait ever low, `rr` unchanged.
6. **ERROR, then reset.** `ramstate = ERROR` for 3 cycles while granted. Required: `err_count = 3` and the wait stays high. Then `nRST = 0` mid-GRANT. Required: `ramREN`/`ramWEN` go to 0 before the next clock edge and `err_count` resets to 0.

Source files
------------

// File: rtl/mem_arbiter.sv
// Shared-RAM arbiter for CPUS cores, each with an I-port and a D-port.
// D-requests beat I-requests; cores are scanned round-robin from rr.
module mem_arbiter #(
    parameter  int CPUS = 2,
    localparam int GW   = (CPUS > 1) ? $clog2(CPUS) : 1
) (
    input  logic                 CLK,
    input  logic                 nRST,
    input  logic [CPUS-1:0]      iREN,
    input  logic [32*CPUS-1:0]   iaddr,
    output logic [CPUS-1:0]      iwait,
    output logic [32*CPUS-1:0]   iload,
    input  logic [CPUS-1:0]      dREN,
    input  logic [CPUS-1:0]      dWEN,
    input  logic [32*CPUS-1:0]   daddr,
    input  logic [32*CPUS-1:0]   dstore,
    output logic [CPUS-1:0]      dwait,
    output logic [32*CPUS-1:0]   dload,
    output logic                 ramREN,
    output logic                 ramWEN,
    output logic [31:0]          ramaddr,
    output logic [31:0]          ramstore,
    input  logic [31:0]          ramload,
    input  logic [1:0]           ramstate,
    output logic [7:0]           err_count,
    output logic                 dbg_state,
    output logic [GW-1:0]        dbg_gcore,
    output logic                 dbg_gdata,
    output logic [GW-1:0]        dbg_rr
);

    localparam logic [1:0] RAM_ACCESS = 2'd2;
    localparam logic [1:0] RAM_ERROR  = 2'd3;

    typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

    state_t        state, state_next;
    logic [GW-1:0] gcore, gcore_next;
    logic          gdata, gdata_next;
    logic [GW-1:0] rr, rr_next;
    logic [7:0]    err_q, err_next;

    logic [CPUS-1:0] dreq, ireq;
    logic [CPUS-1:0] rot_d, rot_i;
    logic            d_found, i_found;
    int              d_off, i_off;
    int              pos;
    logic            sel_valid, sel_data;
    logic [GW-1:0]   sel_core;

    logic            g_iren, g_dren, g_dwen, g_req;
    logic [31:0]     g_iaddr, g_daddr, g_dstore;

    assign dreq = dREN | dWEN;
    assign ireq = iREN;

    // Rotating the request vectors by rr turns the round-robin scan into a
    // fixed lowest-bit-first search.
    assign rot_d = CPUS'({dreq, dreq} >> rr);
    assign rot_i = CPUS'({ireq, ireq} >> rr);

    always_comb begin
        d_found   = 1'b0;
        i_found   = 1'b0;
        d_off     = 0;
        i_off     = 0;
        pos       = 0;
        sel_valid = 1'b0;
        sel_data  = 1'b0;
        sel_core  = '0;
        for (int j = 0; j < CPUS; j++) begin
            if (!d_found && rot_d[j]) begin
                d_found = 1'b1;
                d_off   = j;
            end
            if (!i_found && rot_i[j]) begin
                i_found = 1'b1;
                i_off   = j;
            end
        end
        if (d_found) begin
            sel_valid = 1'b1;
            sel_data  = 1'b1;
            pos       = int'(rr) + d_off;
        end else if (i_found) begin
            sel_valid = 1'b1;
            pos       = int'(rr) + i_off;
        end
        if (pos >= CPUS) begin
            pos = pos - CPUS;
        end
        sel_core = GW'(pos);
    end

    // Live inputs of the granted core.
    always_comb begin
        g_iren   = 1'b0;
        g_dren   = 1'b0;
        g_dwen   = 1'b0;
        g_iaddr  = '0;
        g_daddr  = '0;
        g_dstore = '0;
        for (int n = 0; n < CPUS; n++) begin
            if (gcore == GW'(n)) begin
                g_iren   = iREN[n];
                g_dren   = dREN[n];
                g_dwen   = dWEN[n];
                g_iaddr  = iaddr[32*n +: 32];
                g_daddr  = daddr[32*n +: 32];
                g_dstore = dstore[32*n +: 32];
            end
        end
    end

    assign g_req = gdata ? (g_dren | g_dwen) : g_iren;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state <= IDLE;
            gcore <= '0;
            gdata <= 1'b0;
            rr    <= '0;
            err_q <= '0;
        end else begin
            state <= state_next;
            gcore <= gcore_next;
            gdata <= gdata_next;
            rr    <= rr_next;
            err_q <= err_next;
        end
    end

    always_comb begin
        state_next = state;
        gcore_next = gcore;
        gdata_next = gdata;
        rr_next    = rr;
        err_next   = err_q;
        ramREN     = 1'b0;
        ramWEN     = 1'b0;
        ramaddr    = '0;
        ramstore   = '0;
        iwait      = '1;
        dwait      = '1;
        case (state)
            IDLE: begin
                if (sel_valid) begin
                    state_next = GRANT;
                    gcore_next = sel_core;
                    gdata_next = sel_data;
                end
            end
            GRANT: begin
                ramREN   = gdata ? g_dren : g_iren;
                ramWEN   = gdata ? g_dwen : 1'b0;
                ramaddr  = gdata ? g_daddr : g_iaddr;
                ramstore = gdata ? g_dstore : 32'd0;
                if (ramstate == RAM_ACCESS) begin
                    for (int n = 0; n < CPUS; n++) begin
                        if (gcore == GW'(n)) begin
                            if (gdata) begin
                                dwait[n] = 1'b0;
                            end else begin
                                iwait[n] = 1'b0;
                            end
                        end
                    end
                    state_next = IDLE;
                    if (int'(gcore) == CPUS - 1) begin
                        rr_next = '0;
                    end else begin
                        rr_next = gcore + GW'(1);
                    end
                end else if (!g_req) begin
                    // Requester withdrew: release without ack or rr advance.
                    state_next = IDLE;
                end
                if (ramstate == RAM_ERROR && err_q != 8'hFF) begin
                    err_next = err_q + 8'd1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign iload     = {CPUS{ramload}};
    assign dload     = {CPUS{ramload}};
    assign err_count = err_q;
    assign dbg_state = state;
    assign dbg_gcore = gcore;
    assign dbg_gdata = gdata;
    assign dbg_rr    = rr;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed cycle-by-cycle stimulus, plus an ack
// monitor that matches every low wait bit against an expected queue.
module tb_mem_arbiter;

    localparam int CPUS = 2;
    localparam int GW   = 1;
    localparam int W    = 67;

    localparam logic [1:0] FREE   = 2'd0;
    localparam logic [1:0] BUSY   = 2'd1;
    localparam logic [1:0] ACCESS = 2'd2;
    localparam logic [1:0] ERROR  = 2'd3;

    logic                 CLK;
    logic                 nRST;
    logic [CPUS-1:0]      iREN;
    logic [32*CPUS-1:0]   iaddr;
    logic [CPUS-1:0]      iwait;
    logic [32*CPUS-1:0]   iload;
    logic [CPUS-1:0]      dREN;
    logic [CPUS-1:0]      dWEN;
    logic [32*CPUS-1:0]   daddr;
    logic [32*CPUS-1:0]   dstore;
    logic [CPUS-1:0]      dwait;
    logic [32*CPUS-1:0]   dload;
    logic                 ramREN;
    logic                 ramWEN;
    logic [31:0]          ramaddr;
    logic [31:0]          ramstore;
    logic [31:0]          ramload;
    logic [1:0]           ramstate;
    logic [7:0]           err_count;
    logic                 dbg_state;
    logic [GW-1:0]        dbg_gcore;
    logic                 dbg_gdata;
    logic [GW-1:0]        dbg_rr;

    int tests = 0;
    int fails = 0;

    // {is_data, core[1:0], ramaddr, load}
    logic [W-1:0] exp_q[$];

    mem_arbiter #(.CPUS(CPUS)) dut (
        .CLK(CLK), .nRST(nRST),
        .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dwait(dwait), .dload(dload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr),
        .ramstore(ramstore), .ramload(ramload), .ramstate(ramstate),
        .err_count(err_count),
        .dbg_state(dbg_state), .dbg_gcore(dbg_gcore),
        .dbg_gdata(dbg_gdata), .dbg_rr(dbg_rr)
    );

    // Clock and watchdog
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #100000;
        fails++;
        $display("FAIL watchdog: run did not complete in time");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    // Scoreboard monitor
    task automatic ack_seen(input logic [W-1:0] got);
        logic [W-1:0] e;
        tests++;
        if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL ack_unexpected: got %h expected none", got);
        end else begin
            e = exp_q.pop_front();
            if (got !== e) begin
                fails++;
                $display("FAIL ack_match: got %h expected %h", got, e);
            end
        end
    endtask

    always @(negedge CLK) begin
        if (nRST) begin
            for (int n = 0; n < CPUS; n++) begin
                if (!iwait[n]) ack_seen({1'b0, 2'(n), ramaddr, iload[32*n +: 32]});
                if (!dwait[n]) ack_seen({1'b1, 2'(n), ramaddr, dload[32*n +: 32]});
            end
        end
    end

    // Driver
    initial begin
        nRST = 1'b0; iREN = '0; iaddr = '0; dREN = '0; dWEN = '0;
        daddr = '0; dstore = '0; ramload = '0; ramstate = FREE;

        repeat (2) @(negedge CLK);
        check("rst_iwait", 32'(iwait), 32'h3);
        check("rst_dwait", 32'(dwait), 32'h3);
        check("rst_ramren", 32'(ramREN), 0);
        check("rst_ramwen", 32'(ramWEN), 0);
        check("rst_ramaddr", ramaddr, 0);
        check("rst_ramstore", ramstore, 0);
        check("rst_err", 32'(err_count), 0);
        check("rst_state", 32'(dbg_state), 0);
        check("rst_rr", 32'(dbg_rr), 0);
        check("rst_gcore", 32'(dbg_gcore), 0);
        check("rst_gdata", 32'(dbg_gdata), 0);
        nRST = 1'b1;

        // 1: single I-read with two BUSY cycles
        cyc();
        iREN = 2'b01; iaddr[31:0] = 32'h40; ramstate = BUSY;
        exp_q.push_back({1'b0, 2'd0, 32'h40, 32'hDEADBEEF});
        @(negedge CLK);
        check("t1_idle_ren", 32'(ramREN), 0);
        check("t1_idle_state", 32'(dbg_state), 0);
        cyc();
        @(negedge CLK);
        check("t1_ren", 32'(ramREN), 1);
        check("t1_addr", ramaddr, 32'h40);
        check("t1_wait_busy1", 32'(iwait), 32'h3);
        cyc();
        @(negedge CLK);
        check("t1_wait_busy2", 32'(iwait), 32'h3);
        cyc();
        ramstate = ACCESS; ramload = 32'hDEADBEEF;
        @(negedge CLK);
        check("t1_ack", 32'(iwait), 32'h2);
        check("t1_dwait", 32'(dwait), 32'h3);
        cyc();
        iREN = '0; ramstate = FREE;
        @(negedge CLK);
        check("t1_idle_after", 32'(dbg_state), 0);
        check("t1_rr", 32'(dbg_rr), 1);

        // 2: D over I on core 0
        cyc();
        iREN = 2'b01; dREN = 2'b01; iaddr[31:0] = 32'h44; daddr[31:0] = 32'h200;
        ramstate = ACCESS; ramload = 32'h11111111;
        exp_q.push_back({1'b1, 2'd0, 32'h200, 32'h11111111});
        exp_q.push_back({1'b0, 2'd0, 32'h44, 32'h22222222});
        @(negedge CLK);
        check("t2_idle", 32'(dbg_state), 0);
        cyc();
        @(negedge CLK);
        check("t2_d_ack", 32'(dwait), 32'h2);
        check("t2_i_hold", 32'(iwait), 32'h3);
        check("t2_gdata", 32'(dbg_gdata), 1);
        cyc();
        dREN = '0; ramload = 32'h22222222;
        @(negedge CLK);
        check("t2_gap_state", 32'(dbg_state), 0);
        check("t2_gap_iwait", 32'(iwait), 32'h3);
        check("t2_gap_rr", 32'(dbg_rr), 1);
        cyc();
        @(negedge CLK);
        check("t2_i_ack", 32'(iwait), 32'h2);
        check("t2_i_addr", ramaddr, 32'h44);
        cyc();
        iREN = '0; ramstate = FREE;
        @(negedge CLK);
        check("t2_end_state", 32'(dbg_state), 0);

        // 4: data write on core 1
        cyc();
        dWEN = 2'b10; daddr[63:32] = 32'h100; dstore[63:32] = 32'h12345678;
        ramstate = ACCESS; ramload = 32'h0;
        exp_q.push_back({1'b1, 2'd1, 32'h100, 32'h0});
        @(negedge CLK);
        check("t4_idle", 32'(dbg_state), 0);
        cyc();
        @(negedge CLK);
        check("t4_wen", 32'(ramWEN), 1);
        check("t4_ren", 32'(ramREN), 0);
        check("t4_addr", ramaddr, 32'h100);
        check("t4_store", ramstore, 32'h12345678);
        check("t4_ack", 32'(dwait), 32'h1);
        cyc();
        dWEN = '0; ramstate = FREE;
        @(negedge CLK);
        check("t4_state", 32'(dbg_state), 0);
        check("t4_rr", 32'(dbg_rr), 0);

        // 3: round-robin with both cores holding dREN
        cyc();
        dREN = 2'b11; daddr[31:0] = 32'h300; daddr[63:32] = 32'h304;
        ramstate = ACCESS; ramload = 32'hA5A5A5A5;
        for (int k = 0; k < 4; k++) begin
            exp_q.push_back({1'b1, 2'(k % 2), (k % 2 == 0) ? 32'h300 : 32'h304, 32'hA5A5A5A5});
        end
        @(negedge CLK);
        check("t3_rr_start", 32'(dbg_rr), 0);
        for (int k = 0; k < 4; k++) begin
            cyc();
            @(negedge CLK);
            check("t3_gcore", 32'(dbg_gcore), 32'(k % 2));
            check("t3_grant", 32'(dbg_state), 1);
            cyc();
            if (k == 3) dREN = '0;
            @(negedge CLK);
            check("t3_rr", 32'(dbg_rr), 32'((k + 1) % 2));
            check("t3_gap", 32'(dbg_state), 0);
        end
        ramstate = FREE;

        // 5: abort while BUSY
        cyc();
        dREN = 2'b01; daddr[31:0] = 32'h500; ramstate = BUSY;
        @(negedge CLK);
        check("t5_idle", 32'(dbg_state), 0);
        cyc();
        @(negedge CLK);
        check("t5_ren", 32'(ramREN), 1);
        check("t5_grant", 32'(dbg_state), 1);
        check("t5_dwait", 32'(dwait), 32'h3);
        cyc();
        dREN = '0;
        @(negedge CLK);
        check("t5_ren_drop", 32'(ramREN), 0);
        check("t5_wen_drop", 32'(ramWEN), 0);
        check("t5_still_grant", 32'(dbg_state), 1);
        check("t5_dwait_drop", 32'(dwait), 32'h3);
        cyc();
        ramstate = FREE;
        @(negedge CLK);
        check("t5_state", 32'(dbg_state), 0);
        check("t5_rr", 32'(dbg_rr), 0);

        // 6: ERROR for three cycles, then asynchronous reset mid-grant
        cyc();
        iREN = 2'b01; iaddr[31:0] = 32'h600; ramstate = ERROR;
        @(negedge CLK);
        check("t6_idle_err", 32'(err_count), 0);
        for (int k = 0; k < 3; k++) begin
            cyc();
            @(negedge CLK);
            check("t6_iwait", 32'(iwait), 32'h3);
            check("t6_grant", 32'(dbg_state), 1);
        end
        cyc();
        ramstate = BUSY;
        @(negedge CLK);
        check("t6_err_count", 32'(err_count), 3);
        check("t6_iwait_busy", 32'(iwait), 32'h3);
        check("t6_ren", 32'(ramREN), 1);
        #2;
        nRST = 1'b0;
        #1;
        check("t6_rst_ren", 32'(ramREN), 0);
        check("t6_rst_wen", 32'(ramWEN), 0);
        check("t6_rst_err", 32'(err_count), 0);
        check("t6_rst_state", 32'(dbg_state), 0);
        iREN = '0; ramstate = FREE;
        cyc();
        nRST = 1'b1;
        @(negedge CLK);
        check("t6_post_state", 32'(dbg_state), 0);
        check("t6_post_rr", 32'(dbg_rr), 0);

        check("queue_empty", 32'(exp_q.size()), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
